// File: rtl/seg7_scan_driver_if.sv
// Conversion request/status bundle for the 7-segment scan driver.
// Master drives the value to display; slave reports engine status.
interface seg7_scan_driver_if #(
   parameter int BIN_W = 14
) ();
   logic             load;
   logic [BIN_W-1:0] bin_in;
   logic             busy;
   logic             done;
   logic             overflow;

   modport master (
      output load, bin_in,
      input  busy, done, overflow
   );

   modport slave (
      input  load, bin_in,
      output busy, done, overflow
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Binary to BCD (double-dabble) converter feeding a multiplexed
// 7-segment scanner with leading-zero blanking and overflow dashes.
module seg7_scan_driver #(
   parameter int DIGITS     = 4,
   parameter int BIN_W      = 14,
   parameter int SCAN_DIV   = 1000,
   parameter int ACTIVE_LOW = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   seg7_scan_driver_if.slave bus,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an
);

   localparam int BCD_W = 4 * DIGITS + 4;
   localparam int DSP_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic POL = (ACTIVE_LOW != 0);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CONV = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   function automatic logic [31:0] max_val();
      logic [31:0] v;
      v = 32'd1;
      for (int i = 0; i < DIGITS; i++) v = v * 32'd10;
      return v - 32'd1;
   endfunction

   localparam logic [31:0] MAX_VAL = max_val();

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [BIN_W-1:0] sh;
   logic [BCD_W-1:0] bcd;
   logic [BCD_W-1:0] adj;
   logic             ov_c;
   logic             ov;
   logic [DSP_W-1:0] disp;
   logic [PS_W-1:0]  presc;
   logic [IX_W-1:0]  idx;

   assign bus.busy     = (state != S_IDLE);
   assign bus.done     = (state == S_DONE);
   assign bus.overflow = ov;

   always_comb begin
      adj = '0;
      for (int n = 0; n <= DIGITS; n++) begin
         if (bcd[4*n +: 4] >= 4'd5)
            adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
         else
            adj[4*n +: 4] = bcd[4*n +: 4];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         sh    <= '0;
         bcd   <= '0;
         ov_c  <= 1'b0;
         ov    <= 1'b0;
         disp  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.load) begin
                  sh    <= bus.bin_in;
                  bcd   <= '0;
                  cnt   <= '0;
                  ov_c  <= {{(32-BIN_W){1'b0}}, bus.bin_in} > MAX_VAL;
                  state <= S_CONV;
               end
            end
            S_CONV: begin
               if (cnt == CNT_W'(BIN_W)) begin
                  disp  <= bcd[DSP_W-1:0];
                  ov    <= ov_c;
                  state <= S_DONE;
               end else begin
                  {bcd, sh} <= {adj, sh} << 1;
                  cnt       <= cnt + 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         idx   <= '0;
      end else if (presc == PS_W'(SCAN_DIV - 1)) begin
         presc <= '0;
         if (idx == IX_W'(DIGITS - 1))
            idx <= '0;
         else
            idx <= idx + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   logic [DIGITS:0] zero_hi;
   logic [3:0]      nib;
   logic            blank;
   logic [6:0]      seg_n;

   // zero_hi[i]: digit i and everything above it is zero
   always_comb begin
      zero_hi         = '0;
      zero_hi[DIGITS] = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--)
         zero_hi[i] = zero_hi[i+1] && (disp[4*i +: 4] == 4'd0);
      nib   = 4'd0;
      blank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (IX_W'(i) == idx) begin
            nib   = disp[4*i +: 4];
            blank = (i > 0) && zero_hi[i];
         end
      end
   end

   always_comb begin
      seg_n = 7'b0000000;
      if (ov) begin
         seg_n = 7'b0000001;
      end else if (!blank) begin
         case (nib)
            4'd0:    seg_n = 7'b1111110;
            4'd1:    seg_n = 7'b0110000;
            4'd2:    seg_n = 7'b1101101;
            4'd3:    seg_n = 7'b1111001;
            4'd4:    seg_n = 7'b0110011;
            4'd5:    seg_n = 7'b1011011;
            4'd6:    seg_n = 7'b1011111;
            4'd7:    seg_n = 7'b1110000;
            4'd8:    seg_n = 7'b1111111;
            4'd9:    seg_n = 7'b1111011;
            default: seg_n = 7'b0000000;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= 7'b1111110 ^ {7{POL}};
         an  <= DIGITS'(1) ^ {DIGITS{POL}};
      end else begin
         seg <= seg_n ^ {7{POL}};
         an  <= (DIGITS'(1) << idx) ^ {DIGITS{POL}};
      end
   end

endmodule
